aes_round_sequencer: RTL
========================

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter ROUND_LAT, default 3: cycles spent in each of rounds 1..NR; legal range 1..15.
REQ-002 SHALL have parameter DONE_HOLD, default 4: cycles done stays high; legal range 1..255.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-005 SHALL have port nreset, input, 1: synchronous active-low reset.
REQ-006 SHALL have port load, input, 1: start request, acted on at its rising edge.
REQ-007 SHALL have port key_len, input, 2: 00=AES-128 (NR=10), 01=AES-192 (NR=12), 10=AES-256 (NR=14), 11=reserved, treated as 00.
REQ-008 SHALL have port decrypt, input, 1: 0=encrypt, 1=decrypt.
REQ-009 SHALL have port abort, input, 1: cancel the operation in progress.
REQ-010 SHALL have port round, output, 4: current round number, 0..NR.
REQ-011 SHALL have port key_round, output, 4: round-key index; equals round when encrypting, NR-round when decrypting.
REQ-012 SHALL have port sub_en, output, 1: SubBytes/ShiftRows datapath active.
REQ-013 SHALL have port mix_en, output, 1: MixColumns active.
REQ-014 SHALL have port last_round, output, 1: high while round==NR.
REQ-015 SHALL have port round_step, output, 1: one-cycle strobe on the last cycle of each round, used to capture the datapath state.
REQ-016 SHALL have port busy, output, 1: high in INIT and ROUND.
REQ-017 SHALL have port done, output, 1: result valid.
REQ-018 SHALL have port mode_q, output, 1: decrypt value latched at start.

Function
REQ-019 SHALL implement states IDLE, INIT, ROUND, DONE, plus an internal cycle counter cnt sized $clog2(max(ROUND_LAT,DONE_HOLD)+1) and a registered copy load_q.
REQ-020 SHALL define start as load & ~load_q & ~abort while in IDLE.
REQ-021 SHALL, on start, enter INIT at the next edge and latch NR (from key_len) and decrypt into mode_q.
REQ-022 SHALL ignore key_len and decrypt changes after start until the next start.
REQ-023 SHALL, in INIT: hold round=0 and round_step=1; drive sub_en=0 and mix_en=0; move to ROUND with round=1 and cnt=0 at the next edge.
REQ-024 SHALL, in ROUND: increment cnt every cycle and assert round_step when cnt==ROUND_LAT-1.
REQ-025 SHALL, at a ROUND step with round<NR: increment round and clear cnt.
REQ-026 SHALL, at a ROUND step with round==NR: enter DONE with cnt=0.
REQ-027 SHALL, in ROUND, drive sub_en=1 and drive mix_en=1 only when round<NR.
REQ-028 SHALL keep mix_en low in INIT, IDLE and DONE.
REQ-029 SHALL, in DONE: drive done=1, round=0, key_round=0 and sub_en/mix_en/busy=0; return to IDLE after DONE_HOLD cycles.
REQ-030 SHALL ignore load rising edges that occur in INIT, ROUND or DONE.
REQ-031 SHALL let load_q track load every cycle in every state, so a load held high across DONE does not retrigger.
REQ-032 SHALL raise done exactly 2+NR*ROUND_LAT edges after the edge that samples start.
REQ-033 SHALL, when abort=1 in INIT, ROUND or DONE: enter IDLE at the next edge with all outputs except mode_q cleared and no done pulse.
REQ-034 SHALL give abort priority over start in the same cycle; no start occurs.
REQ-035 SHALL, with ROUND_LAT=1: assert round_step every ROUND cycle, with no idle cycle between rounds.
REQ-036 SHALL produce all outputs from registers or decode of registered state only, with no combinational path from any input.

Reset
REQ-037 SHALL, when nreset=0 at a clock edge, force state IDLE, cnt=0, NR=10, mode_q=0, and round, key_round, sub_en, mix_en, last_round, round_step, busy and done all 0.
REQ-038 SHALL reset load_q to 1, so a load held high through reset release does not start an operation until it goes low and high again.
REQ-039 SHALL, when reset is applied mid-operation, produce IDLE on the next cycle with no done.

Verification
REQ-040 SHALL cover: key_len=00, decrypt=0, ROUND_LAT=3, single load pulse -> round steps 0,1..10, mix_en low in round 10, done high 32 cycles after start for 4 cycles, then busy=0.
REQ-041 SHALL cover: key_len=10, decrypt=1 -> key_round runs 14,13..0 while round runs 0..14, done at 44 cycles, mode_q=1.
REQ-042 SHALL cover: key_len=01, with key_len switched to 00 at round 3 -> run completes with NR=12, done at 38 cycles.
REQ-043 SHALL cover: abort asserted in round 5 -> IDLE next cycle, done never high; then a fresh load edge -> normal full run.
REQ-044 SHALL cover: load held high through reset release and through a full run -> exactly one operation after load toggles low then high; no restart from DONE.
REQ-045 SHALL cover: ROUND_LAT=1, key_len=11 -> treated as NR=10, round_step high on 11 consecutive cycles, done at 12 cycles.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES round sequencer driving the round datapath
// Every output is a flop loaded from a decode of the current state, so it appears one cycle after that state.
module aes_round_sequencer #(
    parameter int ROUND_LAT = 3,
    parameter int DONE_HOLD = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       load,
    input  logic [1:0] key_len,
    input  logic       decrypt,
    input  logic       abort,
    output logic [3:0] round,
    output logic [3:0] key_round,
    output logic       sub_en,
    output logic       mix_en,
    output logic       last_round,
    output logic       round_step,
    output logic       busy,
    output logic       done,
    output logic       mode_q
);

    localparam int CNT_MAX = (ROUND_LAT > DONE_HOLD) ? ROUND_LAT : DONE_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RL_LAST = CW'(ROUND_LAT - 1);
    localparam logic [CW-1:0] DH_LAST = CW'(DONE_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    nr_q, nr_d;
    logic [3:0]    rcnt_q, rcnt_d;
    logic          mode_d;
    logic          load_q, load_d;
    logic          start;

    logic [3:0] round_q, round_d;
    logic [3:0] key_round_q, key_round_d;
    logic       sub_en_q, sub_en_d;
    logic       mix_en_q, mix_en_d;
    logic       last_round_q, last_round_d;
    logic       round_step_q, round_step_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nr_d    = nr_q;
        rcnt_d  = rcnt_q;
        mode_d  = mode_q;
        load_d  = load;
        start   = (state_q == S_IDLE) && load && !load_q && !abort;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    rcnt_d  = 4'd0;
                    mode_d  = decrypt;
                    unique case (key_len)
                        2'b01:   nr_d = 4'd12;
                        2'b10:   nr_d = 4'd14;
                        default: nr_d = 4'd10;
                    endcase
                end
            end
            S_INIT: begin
                state_d = S_ROUND;
                rcnt_d  = 4'd1;
                cnt_d   = '0;
            end
            S_ROUND: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RL_LAST) begin
                    cnt_d = '0;
                    if (rcnt_q == nr_q) begin
                        state_d = S_DONE;
                        rcnt_d  = 4'd0;
                    end else begin
                        rcnt_d = rcnt_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DH_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rcnt_d  = 4'd0;
        end
    end

    // Output decode; an abort wipes the outputs on the same edge that returns to IDLE.
    always_comb begin
        round_d      = 4'd0;
        key_round_d  = 4'd0;
        sub_en_d     = 1'b0;
        mix_en_d     = 1'b0;
        last_round_d = 1'b0;
        round_step_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        if (!abort) begin
            unique case (state_q)
                S_INIT: begin
                    key_round_d  = mode_q ? (nr_q - rcnt_q) : rcnt_q;
                    round_step_d = 1'b1;
                    busy_d       = 1'b1;
                end
                S_ROUND: begin
                    round_d      = rcnt_q;
                    key_round_d  = mode_q ? (nr_q - rcnt_q) : rcnt_q;
                    sub_en_d     = 1'b1;
                    mix_en_d     = (rcnt_q < nr_q);
                    last_round_d = (rcnt_q == nr_q);
                    round_step_d = (cnt_q == RL_LAST);
                    busy_d       = 1'b1;
                end
                S_DONE:  done_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            nr_q         <= 4'd10;
            rcnt_q       <= 4'd0;
            mode_q       <= 1'b0;
            load_q       <= 1'b1;
            round_q      <= 4'd0;
            key_round_q  <= 4'd0;
            sub_en_q     <= 1'b0;
            mix_en_q     <= 1'b0;
            last_round_q <= 1'b0;
            round_step_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nr_q         <= nr_d;
            rcnt_q       <= rcnt_d;
            mode_q       <= mode_d;
            load_q       <= load_d;
            round_q      <= round_d;
            key_round_q  <= key_round_d;
            sub_en_q     <= sub_en_d;
            mix_en_q     <= mix_en_d;
            last_round_q <= last_round_d;
            round_step_q <= round_step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign round      = round_q;
    assign key_round  = key_round_q;
    assign sub_en     = sub_en_q;
    assign mix_en     = mix_en_q;
    assign last_round = last_round_q;
    assign round_step = round_step_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
